flow_resolver: RTL and testbench

FLOW_RESOLVER -- requirements
Module: flow_resolver

---
 rtl/flow_pkg.sv | 41 ++++
 rtl/flow_resolver_if.sv | 22 ++
 rtl/flow_resolver_cmp.sv | 22 ++
 rtl/flow_resolver.sv | 121 ++++++++++++
 tb/tb_flow_resolver.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/flow_pkg.sv
// Shared constants, state/kind enums and immediate decoders for the flow resolver.
// Optional JALR resolution is controlled by the FLOW_JALR_EN macro (see flow_resolver.sv).
package flow_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_NOP    = 7'b0010011;

    localparam logic [2:0] F3_EQ  = 3'b000;
    localparam logic [2:0] F3_NE  = 3'b001;
    localparam logic [2:0] F3_LT  = 3'b100;
    localparam logic [2:0] F3_GE  = 3'b101;
    localparam logic [2:0] F3_LTU = 3'b110;
    localparam logic [2:0] F3_GEU = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RESOLVE  = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_BRANCH = 2'd0,
        K_JAL    = 2'd1,
        K_JALR   = 2'd2
    } kind_t;

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

endpackage

// File: rtl/flow_resolver_if.sv
// Fetch-side bundle between the instruction path and the flow resolver.
interface flow_resolver_if;
    logic [31:0] IP;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [6:0]  OP;
    logic [31:0] up_amt;
    logic        b_taken;
    logic [31:0] link_addr;
    logic        link_we;

    modport master (
        output IP, instr, rs1_val, rs2_val,
        input  OP, up_amt, b_taken, link_addr, link_we
    );

    modport slave (
        input  IP, instr, rs1_val, rs2_val,
        output OP, up_amt, b_taken, link_addr, link_we
    );
endinterface

// File: rtl/flow_resolver_cmp.sv
// Combinational branch condition evaluator; unsupported funct3 codes never take.
module branch_cmp
    import flow_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  funct3,
    output logic        taken
);
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_EQ:   taken = (a == b);
            F3_NE:   taken = (a != b);
            F3_LT:   taken = ($signed(a) <  $signed(b));
            F3_GE:   taken = ($signed(a) >= $signed(b));
            F3_LTU:  taken = (a <  b);
            F3_GEU:  taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/flow_resolver.sv
// Resolves BRANCH/JAL(/JALR) into PC offset, taken flag and link write, in lock-step with the PC.
// Define FLOW_JALR_EN to resolve JALR; otherwise JALR is shown to the PC as a NOP and ignored.
module flow_resolver
    import flow_pkg::*;
(
    input  logic     CLK,
    input  logic     RESET_N,
    flow_resolver_if.slave bus
);
    state_t      state, state_nxt;
    kind_t       cap_kind;
    logic [2:0]  cap_f3;
    logic [6:0]  cap_op;
    logic [31:0] cap_a, cap_b, cap_off, cap_link;

    logic [6:0]  opc;
    logic        is_cf;
    logic        capture;
    kind_t       kind_now;
    logic [31:0] off_now;
    logic        cmp_taken;

    logic [6:0]  op_o;
    logic [31:0] up_o;
    logic        bt_o;
    logic        we_o;

    assign opc = bus.instr[6:0];

    always_comb begin
        is_cf    = 1'b0;
        kind_now = K_BRANCH;
        off_now  = imm_b(bus.instr);
        case (opc)
            OPC_BRANCH: is_cf = 1'b1;
            OPC_JAL: begin
                is_cf    = 1'b1;
                kind_now = K_JAL;
                off_now  = imm_j(bus.instr);
            end
`ifdef FLOW_JALR_EN
            OPC_JALR: begin
                is_cf    = 1'b1;
                kind_now = K_JALR;
                // Absolute target turned into a PC-relative offset for the counter
                off_now  = ((bus.rs1_val + imm_i(bus.instr)) & ~32'd1) - bus.IP;
            end
`endif
            default: ;
        endcase
    end

    assign capture = (state == ST_RUN) && is_cf;

    branch_cmp u_cmp (
        .a      (cap_a),
        .b      (cap_b),
        .funct3 (cap_f3),
        .taken  (cmp_taken)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        op_o      = opc;
        up_o      = 32'd0;
        bt_o      = 1'b0;
        we_o      = 1'b0;
        case (state)
            ST_RUN: begin
`ifndef FLOW_JALR_EN
                if (opc == OPC_JALR) op_o = OPC_NOP;
`endif
                if (capture) state_nxt = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                op_o = cap_op;
                up_o = cap_off;
                bt_o = (cap_kind == K_BRANCH) && cmp_taken;
                if (bt_o || cap_kind != K_BRANCH) state_nxt = ST_REDIRECT;
                else                              state_nxt = ST_RUN;
            end
            ST_REDIRECT: begin
                we_o      = (cap_kind != K_BRANCH);
                state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cap_kind <= K_BRANCH;
            cap_f3   <= 3'd0;
            cap_op   <= 7'd0;
            cap_a    <= 32'd0;
            cap_b    <= 32'd0;
            cap_off  <= 32'd0;
            cap_link <= 32'd0;
        end else if (capture) begin
            cap_kind <= kind_now;
            cap_f3   <= bus.instr[14:12];
            cap_op   <= opc;
            cap_a    <= bus.rs1_val;
            cap_b    <= bus.rs2_val;
            cap_off  <= off_now;
            cap_link <= bus.IP + 32'd4;
        end
    end

    assign bus.OP        = op_o;
    assign bus.up_amt    = up_o;
    assign bus.b_taken   = bt_o;
    assign bus.link_we   = we_o;
    assign bus.link_addr = cap_link;

endmodule

// File: tb/tb_flow_resolver.sv
// Directed plus random checks of flow_resolver against a cycle-schedule reference model.
module tb_flow_resolver;

    localparam int KNONE = 0, KBR = 1, KJAL = 2, KJALR = 3;
`ifdef FLOW_JALR_EN
    localparam bit JALR_EN = 1'b1;
`else
    localparam bit JALR_EN = 1'b0;
`endif

    typedef struct {
        bit          raw_op;
        logic [6:0]  op;
        logic [31:0] up;
        logic        bt;
        logic        we;
        logic [31:0] la;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t plan[$];

    flow_resolver_if f();

    flow_resolver dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [31:0] off, input logic [2:0] f3);
        return {off[12], off[10:5], 5'd2, 5'd1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] off);
        return {off[20], off[10:1], off[11], off[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [31:0] off);
        return {off[11:0], 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One fetch cycle: drive, check against the schedule, then let the model react.
    task automatic step(input logic [31:0] ip, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input int kind, input logic [31:0] imm);
        exp_t e;
        logic [31:0] off;
        bit tk;
        @(negedge clk);
        f.IP = ip; f.instr = ins; f.rs1_val = a; f.rs2_val = b;
        #1;
        if (plan.size() == 0) begin
            chk("run_op", f.OP, (kind == KJALR && !JALR_EN) ? 32'h13 : {25'd0, ins[6:0]});
            chk("run_up", f.up_amt, 0);
            chk("run_bt", f.b_taken, 0);
            chk("run_we", f.link_we, 0);
            if (kind != KNONE && (kind != KJALR || JALR_EN)) begin
                tk  = (kind == KBR) && ref_taken(ins[14:12], a, b);
                off = (kind == KJALR) ? (((a + imm) & ~32'd1) - ip) : imm;
                plan.push_back('{1'b0, ins[6:0], off, tk, 1'b0, 32'd0});
                if (tk || kind != KBR)
                    plan.push_back('{1'b1, 7'd0, 32'd0, 1'b0, kind != KBR, ip + 32'd4});
            end
        end else begin
            e = plan.pop_front();
            chk("sch_op", f.OP, e.raw_op ? {25'd0, ins[6:0]} : {25'd0, e.op});
            chk("sch_up", f.up_amt, e.up);
            chk("sch_bt", f.b_taken, e.bt);
            chk("sch_we", f.link_we, e.we);
            if (e.we) chk("sch_la", f.link_addr, e.la);
        end
    endtask

    initial begin
        logic [31:0] r, ip, a, b, imm, ins;
        logic [6:0] others [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                   7'b0100011, 7'b0110111, 7'b0010111};
        f.IP = 0; f.instr = 0; f.rs1_val = 0; f.rs2_val = 0;
        #1;
        chk("rst_op", f.OP, 0);
        chk("rst_up", f.up_amt, 0);
        chk("rst_bt", f.b_taken, 0);
        chk("rst_la", f.link_addr, 0);
        chk("rst_we", f.link_we, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // BEQ taken, no link strobe
        step(32'h40, enc_b(32'd16, 3'b000), 5, 5, KBR, 32'd16);
        step(32'h44, 32'h13, 0, 0, KNONE, 0);
        chk("beq_up", f.up_amt, 32'h10);
        chk("beq_bt", f.b_taken, 1);
        step(32'h50, 32'h13, 0, 0, KNONE, 0);
        chk("beq_we", f.link_we, 0);
        step(32'h54, 32'h13, 0, 0, KNONE, 0);

        // BLTU not taken vs BLT taken on same operands
        step(32'h60, enc_b(32'd8, 3'b110), 32'hFFFF_FFFF, 1, KBR, 32'd8);
        step(32'h64, 32'h13, 0, 0, KNONE, 0);
        chk("bltu_bt", f.b_taken, 0);
        step(32'h68, 32'h13, 0, 0, KNONE, 0);
        step(32'h6C, enc_b(32'd8, 3'b100), 32'hFFFF_FFFF, 1, KBR, 32'd8);
        step(32'h70, 32'h13, 0, 0, KNONE, 0);
        chk("blt_bt", f.b_taken, 1);
        step(32'h74, 32'h13, 0, 0, KNONE, 0);

        // JAL backwards with link
        step(32'h100, enc_j(32'hFFFF_FFF8), 0, 0, KJAL, 32'hFFFF_FFF8);
        step(32'h104, 32'h13, 0, 0, KNONE, 0);
        chk("jal_up", f.up_amt, 32'hFFFF_FFF8);
        chk("jal_bt", f.b_taken, 0);
        step(32'hF8, 32'h13, 0, 0, KNONE, 0);
        chk("jal_we", f.link_we, 1);
        chk("jal_la", f.link_addr, 32'h104);

        // JALR
        step(32'h80, enc_jalr(32'd4), 32'h203, 0, KJALR, 32'd4);
        if (JALR_EN) begin
            step(32'h84, 32'h13, 0, 0, KNONE, 0);
            chk("jalr_up", f.up_amt, 32'h186);
            step(32'h206, 32'h13, 0, 0, KNONE, 0);
        end else begin
            chk("jalr_nop", f.OP, 32'h13);
        end
        step(32'h208, 32'h13, 0, 0, KNONE, 0);

        // Reset during RESOLVE of a JAL aborts the redirect
        step(32'h200, enc_j(32'd64), 0, 0, KJAL, 32'd64);
        @(negedge clk);
        f.instr = 0;
        rst_n = 1'b0;
        #1;
        chk("ar_up", f.up_amt, 0);
        chk("ar_bt", f.b_taken, 0);
        chk("ar_la", f.link_addr, 0);
        chk("ar_we", f.link_we, 0);
        chk("ar_op", f.OP, 0);
        plan.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h204, 32'h13, 0, 0, KNONE, 0);
        chk("ar_we2", f.link_we, 0);
        step(32'h208, 32'h13, 0, 0, KNONE, 0);

        // Branch at redirect target is ignored; the next one is captured
        step(32'h300, enc_b(32'd32, 3'b001), 1, 2, KBR, 32'd32);
        step(32'h304, 32'h13, 0, 0, KNONE, 0);
        step(32'h320, enc_b(32'd12, 3'b000), 7, 7, KBR, 32'd12);
        step(32'h324, enc_b(32'd20, 3'b000), 7, 7, KBR, 32'd20);
        step(32'h328, 32'h13, 0, 0, KNONE, 0);
        chk("tgt_up", f.up_amt, 32'd20);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            r  = $urandom;
            ip = {$urandom, 2'b00} & 32'h000F_FFFC;
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    imm = {{19{r[12]}}, r[12:1], 1'b0};
                    step(ip, enc_b(imm, 3'($urandom_range(0, 7))), a, b, KBR, imm);
                end
                3: begin
                    imm = {{11{r[20]}}, r[20:1], 1'b0};
                    step(ip, enc_j(imm), a, b, KJAL, imm);
                end
                4: begin
                    imm = {{20{r[11]}}, r[11:0]};
                    step(ip, enc_jalr(imm), a, b, KJALR, imm);
                end
                default: begin
                    ins = {r[31:7], others[$urandom_range(0, 5)]};
                    step(ip, ins, a, b, KNONE, 0);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
